uart_tx_ctrl: RTL and testbench

//   UART transmit framer/controller sitting directly upstream of the 8-bit

---
 rtl/uart_tx_ctrl.sv | 73 +++++++
 tb/tb_uart_tx_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame controller driving an external load/shift serializer
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] par_data_o,
  output logic       load_o,
  output logic       shift_o,
  input  logic       sr_bit_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic sidx, par, bit_end, stop_last;

  always_ff @(posedge Clk)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sidx       <= 1'b0;
      par        <= 1'b0;
      par_data_o <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == IDLE || bit_end) ? '0 : cnt + W'(1);
      idx   <= state != DATA ? 3'd0 : bit_end ? idx + 3'd1 : idx;
      sidx  <= state == STOP ? sidx ^ bit_end : 1'b0;
      if (tx_valid_i && tx_ready_o) begin
        par_data_o <= tx_data_i;
        par        <= ^tx_data_i ^ 1'(PARITY_ODD);
      end
    end

  // sidx marks the second stop bit; with one stop bit the first is already last
  always_comb begin
    bit_end    = cnt == LAST;
    stop_last  = STOP_BITS == 1 || sidx;
    tx_ready_o = state == IDLE;
    busy_o     = state != IDLE;
    load_o     = state == START && cnt == '0;
    shift_o    = bit_end && (state == START || (state == DATA && idx != 3'd7));
    tx_done_o  = state == STOP && bit_end && stop_last;
    tx_o       = state == START ? 1'b0 : state == DATA ? sr_bit_i : state == PARITY ? par : 1'b1;
    nxt        = state;
    case (state)
      IDLE:    nxt = tx_valid_i ? START : IDLE;
      START:   nxt = bit_end ? DATA : START;
      DATA:    nxt = (bit_end && idx == 3'd7) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = (bit_end && stop_last) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: four controller configurations (8N1, 8E1, 8O1, 8N2) with serializer models
module tb_uart_tx_ctrl;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data [4];
  logic valid [4];
  logic ready [4], busy [4], load [4], shift [4], tx [4], done [4];
  logic [7:0] pd [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_u
    logic [7:0] sr;
    logic sr_bit;
    uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN(g == 1 || g == 2),
      .PARITY_ODD(g == 2),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) u (
      .Clk(clk), .rst(rst), .tx_data_i(data[g]), .tx_valid_i(valid[g]),
      .tx_ready_o(ready[g]), .par_data_o(pd[g]), .load_o(load[g]), .shift_o(shift[g]),
      .sr_bit_i(sr_bit), .tx_o(tx[g]), .busy_o(busy[g]), .tx_done_o(done[g])
    );
    // serializer: shift moves the next LSB onto the registered serial output
    always_ff @(posedge clk)
      if (rst) begin
        sr     <= '0;
        sr_bit <= 1'b0;
      end else if (load[g]) sr <= pd[g];
      else if (shift[g]) begin
        sr_bit <= sr[0];
        sr     <= sr >> 1;
      end
  end

  function automatic bit has_par(int k);
    return k == 1 || k == 2;
  endfunction

  function automatic int mlen(int k);
    return (1 + 8 + int'(has_par(k)) + (k == 3 ? 2 : 1)) * CPB;
  endfunction

  function automatic logic mpar(int k, logic [7:0] b);
    return ^b ^ (k == 2);
  endfunction

  function automatic logic mbit(int k, logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (has_par(k) && i == 9) return mpar(k, b);
    return 1'b1;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic run_frame(int k, logic [7:0] b, bit keep, bit inj, int elen, logic epar);
    int t = 0, nl = 0, ns = 0, both = 0, bad = 0, first = -1, rb = 0, pb = 0, nd = 0, dat = -1;
    logic ptx = 1'bx;
    while (ready[k] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("ready_wait[%0d]", k), int'(ready[k] === 1'b1), 1);
    data[k] = b;
    valid[k] = 1'b1;
    for (int j = 1; j <= elen; j++) begin
      @(negedge clk);
      if (j == 1 && !keep) valid[k] = 1'b0;
      if (inj && j == 20) begin
        data[k] = ~b;
        valid[k] = 1'b1;
      end
      if (inj && j == 21) valid[k] = 1'b0;
      nl += int'(load[k]);
      ns += int'(shift[k]);
      both += int'(load[k] & shift[k]);
      if (tx[k] !== mbit(k, b, (j - 1) / CPB)) begin
        bad++;
        if (first < 0) first = j;
      end
      if (ready[k] !== 1'b0 || busy[k] !== 1'b1) rb++;
      if (pd[k] !== b) pb++;
      if (done[k] === 1'b1) begin
        nd++;
        if (dat < 0) dat = j;
      end
      if (j == 9 * CPB + 2) ptx = tx[k];
    end
    chk($sformatf("line_err[%0d] b=%h first=%0d", k, b, first), bad, 0);
    chk($sformatf("loads[%0d]", k), nl, 1);
    chk($sformatf("shifts[%0d]", k), ns, 8);
    chk($sformatf("load_and_shift[%0d]", k), both, 0);
    chk($sformatf("ready_in_frame[%0d]", k), rb, 0);
    chk($sformatf("par_data_hold[%0d]", k), pb, 0);
    chk($sformatf("done_cycle[%0d]", k), dat, elen);
    chk($sformatf("done_count[%0d]", k), nd, 1);
    if (has_par(k)) chk($sformatf("parity[%0d] b=%h", k, b), int'(ptx), int'(epar));
    @(negedge clk);
    chk($sformatf("gap_ready[%0d]", k), int'(ready[k]), 1);
    chk($sformatf("gap_tx[%0d]", k), int'(tx[k]), 1);
    chk($sformatf("gap_done[%0d]", k), int'(done[k]), 0);
  endtask

  typedef struct {
    int k;
    logic [7:0] b;
    bit keep;
    bit inj;
    int len;
    logic par;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 40, 1'bx};
    tbl[1] = '{1, 8'hA5, 1'b0, 1'b0, 44, 1'b0};
    tbl[2] = '{2, 8'hA5, 1'b0, 1'b0, 44, 1'b1};
    tbl[3] = '{1, 8'h07, 1'b0, 1'b0, 44, 1'b1};
    tbl[4] = '{3, 8'h00, 1'b1, 1'b0, 44, 1'bx};
    tbl[5] = '{3, 8'hFF, 1'b0, 1'b0, 44, 1'bx};
    tbl[6] = '{0, 8'h5A, 1'b0, 1'b1, 40, 1'bx};
    tbl[7] = '{2, 8'h07, 1'b0, 1'b1, 44, 1'b0};
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b0;
      data[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("reset_par_data[%0d]", k), int'(pd[k]), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (tx[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0 || load[k] !== 1'b0 ||
            shift[k] !== 1'b0 || done[k] !== 1'b0) bad++;
    end
    chk("idle_outputs", bad, 0);

    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].k, tbl[i].b, tbl[i].keep, tbl[i].inj, tbl[i].len, tbl[i].par);

    // reset during data bit 3 of 0x3C, then a clean frame
    data[0] = 8'h3C;
    valid[0] = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 1) valid[0] = 1'b0;
    end
    chk("pre_reset_bit3", int'(tx[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_reset_tx", int'(tx[0]), 1);
    chk("post_reset_ready", int'(ready[0]), 1);
    chk("post_reset_busy", int'(busy[0]), 0);
    chk("post_reset_par_data", int'(pd[0]), 0);
    run_frame(0, 8'h81, 1'b0, 1'b0, 40, 1'bx);

    for (int r = 0; r < 12; r++) begin
      int k = int'($urandom_range(0, 3));
      logic [7:0] b = 8'($urandom);
      run_frame(k, b, 1'b0, 1'($urandom_range(0, 1)), mlen(k), mpar(k, b));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
